// File: rtl/cache_control.sv
// -----------------------------------------------------------------------------
// cache_control
//   Control FSM for a 2-way set-associative, write-back, write-allocate cache.
//   It sequences hit service, dirty-victim writeback and line allocation, drives
//   the datapath write enables and mux selects, and keeps saturating hit/miss
//   statistics counters.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   mem_read, mem_write      CPU request (held until mem_resp)
//   mem_resp                 one-cycle completion pulse to the CPU
//   pmem_resp                physical memory completion pulse
//   pmem_read, pmem_write    line fetch / writeback requests (held until pmem_resp)
//   tag_match, whichtag      tag hit indication and matching way
//   valid                    valid bit of the matching way
//   dirty                    dirty bit of the LRU (victim) way
//   lru_out                  LRU way of the indexed set
//   write0/1                 tag/data/valid write enables per way
//   wdirty0/1, dirty0/1_val  dirty bit write enables and values per way
//   inrw1                    update LRU to point at the non-accessed way
//   inw1                     data-in select: 0 = pmem line, 1 = merged CPU write
//   hit_count, miss_count    saturating statistics counters
// -----------------------------------------------------------------------------
module cache_control #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 mem_read,
  input  logic                 mem_write,
  output logic                 mem_resp,
  input  logic                 pmem_resp,
  output logic                 pmem_read,
  output logic                 pmem_write,
  input  logic                 tag_match,
  input  logic                 whichtag,
  input  logic                 valid,
  input  logic                 dirty,
  input  logic                 lru_out,
  output logic                 write0,
  output logic                 write1,
  output logic                 wdirty0,
  output logic                 wdirty1,
  output logic                 dirty0_val,
  output logic                 dirty1_val,
  output logic                 inrw1,
  output logic                 inw1,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 miss_pending_q, miss_pending_d;
  logic [CNT_WIDTH-1:0] hit_count_q, hit_count_d;
  logic [CNT_WIDTH-1:0] miss_count_q, miss_count_d;

  logic req;
  logic hit;
  logic is_write;

  assign req      = mem_read | mem_write;
  assign hit      = tag_match & valid;
  // A simultaneous read and write is serviced as a write.
  assign is_write = mem_write;

  // Mealy output decode, next-state and counter update.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d        = state_q;
    miss_pending_d = miss_pending_q;
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    mem_resp       = 1'b0;
    pmem_read      = 1'b0;
    pmem_write     = 1'b0;
    write0         = 1'b0;
    write1         = 1'b0;
    wdirty0        = 1'b0;
    wdirty1        = 1'b0;
    dirty0_val     = 1'b0;
    dirty1_val     = 1'b0;
    inrw1          = 1'b0;
    inw1           = 1'b0;

    // Outputs are forced low for the whole time reset is held, including the
    // IDLE hit path that would otherwise decode straight from the inputs.
    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            inrw1    = 1'b1;
            if (is_write) begin
              inw1 = 1'b1;
              if (whichtag) begin
                write1     = 1'b1;
                wdirty1    = 1'b1;
                dirty1_val = 1'b1;
              end else begin
                write0     = 1'b1;
                wdirty0    = 1'b1;
                dirty0_val = 1'b1;
              end
            end
          end else if (req) begin
            miss_pending_d = 1'b1;
            state_d        = dirty ? WRITEBACK : ALLOCATE;
          end else begin
            // An abandoned miss must not be credited to a later request.
            miss_pending_d = 1'b0;
          end
        end

        WRITEBACK: begin
          pmem_write = 1'b1;
          if (pmem_resp) begin
            // If the CPU withdrew its request, finish here and skip the fetch.
            state_d = req ? ALLOCATE : IDLE;
            if (!req) miss_pending_d = 1'b0;
          end
        end

        ALLOCATE: begin
          pmem_read = 1'b1;
          if (pmem_resp) begin
            // Fill the victim way with a clean copy of the fetched line.
            if (lru_out) begin
              write1  = 1'b1;
              wdirty1 = 1'b1;
            end else begin
              write0  = 1'b1;
              wdirty0 = 1'b1;
            end
            state_d = IDLE;
            if (!req) miss_pending_d = 1'b0;
          end
        end

        default: state_d = IDLE;
      endcase

      // Statistics: a response that closes a miss counts as a miss.
      if (mem_resp) begin
        if (miss_pending_q) begin
          miss_pending_d = 1'b0;
          if (miss_count_q != '1) miss_count_d = miss_count_q + CNT_WIDTH'(1);
        end else begin
          if (hit_count_q != '1) hit_count_d = hit_count_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q        <= IDLE;
      miss_pending_q <= 1'b0;
      hit_count_q    <= '0;
      miss_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      miss_pending_q <= miss_pending_d;
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_control.sv
// -----------------------------------------------------------------------------
// tb_cache_control
//   Self-checking bench for cache_control: table of single-cycle IDLE vectors,
//   hand-written multi-cycle miss/reset sequences, and randomized transactions
//   checked against a transaction-level reference model.
// -----------------------------------------------------------------------------
module tb_cache_control;

  localparam int CW = 4;  // small counters so saturation is reachable

  logic clk = 1'b0;
  logic reset;
  logic mem_read, mem_write, pmem_resp, tag_match, whichtag, valid, dirty, lru_out;
  logic mem_resp, pmem_read, pmem_write, write0, write1, wdirty0, wdirty1;
  logic dirty0_val, dirty1_val, inrw1, inw1;
  logic [CW-1:0] hit_count, miss_count;

  int n_tests = 0;
  int n_fail  = 0;
  int hit_m   = 0;
  int miss_m  = 0;

  // Output bundle, bit 10 down to 0.
  logic [10:0] outs;
  assign outs = {mem_resp, pmem_read, pmem_write, write0, write1, wdirty0, wdirty1,
                 dirty0_val, dirty1_val, inrw1, inw1};

  cache_control #(.CNT_WIDTH(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_resp  (mem_resp),
    .pmem_resp (pmem_resp),
    .pmem_read (pmem_read),
    .pmem_write(pmem_write),
    .tag_match (tag_match),
    .whichtag  (whichtag),
    .valid     (valid),
    .dirty     (dirty),
    .lru_out   (lru_out),
    .write0    (write0),
    .write1    (write1),
    .wdirty0   (wdirty0),
    .wdirty1   (wdirty1),
    .dirty0_val(dirty0_val),
    .dirty1_val(dirty1_val),
    .inrw1     (inrw1),
    .inw1      (inw1),
    .hit_count (hit_count),
    .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference rules (per-cycle expected output bundles) ----
  function automatic logic [10:0] o_hit(input logic is_wr, input logic way);
    logic [10:0] v;
    v     = '0;
    v[10] = 1'b1;  // mem_resp
    v[1]  = 1'b1;  // inrw1
    if (is_wr) begin
      v[0] = 1'b1;  // inw1
      if (way) begin v[6] = 1'b1; v[4] = 1'b1; v[2] = 1'b1; end
      else     begin v[7] = 1'b1; v[5] = 1'b1; v[3] = 1'b1; end
    end
    return v;
  endfunction

  function automatic logic [10:0] o_wb();
    logic [10:0] v;
    v    = '0;
    v[8] = 1'b1;
    return v;
  endfunction

  function automatic logic [10:0] o_alloc(input logic resp, input logic lru);
    logic [10:0] v;
    v    = '0;
    v[9] = 1'b1;
    if (resp) begin
      if (lru) begin v[6] = 1'b1; v[4] = 1'b1; end
      else     begin v[7] = 1'b1; v[5] = 1'b1; end
    end
    return v;
  endfunction

  function automatic int sat(input int x);
    return (x >= (1 << CW) - 1) ? x : x + 1;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check_o(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_c(input string name, input logic [CW-1:0] act, input int exp);
    n_tests++;
    if (act !== CW'(exp)) begin
      n_fail++;
      $display("FAIL %s: counter got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_counts(input string name);
    check_c({name, " hit_count"}, hit_count, hit_m);
    check_c({name, " miss_count"}, miss_count, miss_m);
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic tm, input logic v,
                        input logic wt, input logic d, input logic lru, input logic pr);
    mem_read  = rd;
    mem_write = wr;
    tag_match = tm;
    valid     = v;
    whichtag  = wt;
    dirty     = d;
    lru_out   = lru;
    pmem_resp = pr;
  endtask

  // Inputs are driven 1 time unit after a rising edge; outputs are checked at
  // the falling edge; then advance to 1 unit after the next rising edge.
  task automatic step(input string name, input logic [10:0] exp);
    #4;
    check_o(name, outs, exp);
    @(posedge clk);
    #1;
  endtask

  // ---------------- table of single-cycle IDLE vectors ----------------
  typedef struct {
    logic        rd, wr, tm, v, wt, d, lru, pr;
    logic [10:0] exp;
    logic        is_hit;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'b0000_0000_000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'b1000_0000_010, 1'b1};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'b1000_0000_010, 1'b1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 11'b1001_0101_011, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 11'b1000_1010_111, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 11'b1000_1010_111, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 11'b1001_0101_011, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 11'b0000_0000_000, 1'b0};

    // ---------------- reset state ----------------
    reset = 1'b1;
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);  // hit would decode if not gated
    #2;
    check_o("outputs low in reset", outs, 11'b0);
    check_counts("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;

    // ---------------- read miss to an empty set, lru_out=1 ----------------
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("clean miss idle", 11'b0);
    step("clean miss alloc1", o_alloc(1'b0, 1'b1));
    step("clean miss alloc2", o_alloc(1'b0, 1'b1));
    pmem_resp = 1'b1;
    step("clean miss alloc3 fill", o_alloc(1'b1, 1'b1));
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("clean miss response", o_hit(1'b0, 1'b1));
    miss_m = sat(miss_m);
    check_counts("after clean miss");

    // Same address again: immediate hit.
    step("repeat read hit", o_hit(1'b0, 1'b1));
    hit_m = sat(hit_m);
    check_counts("after repeat hit");

    // ---------------- table-driven IDLE vectors ----------------
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].rd, tbl[i].wr, tbl[i].tm, tbl[i].v, tbl[i].wt, tbl[i].d,
             tbl[i].lru, tbl[i].pr);
      step($sformatf("table vector %0d", i), tbl[i].exp);
      if (tbl[i].is_hit) hit_m = sat(hit_m);
      check_counts($sformatf("table vector %0d", i));
    end

    // ---------------- dirty miss, lru_out=0 ----------------
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("dirty miss idle", 11'b0);
    step("dirty miss wb1", o_wb());
    pmem_resp = 1'b1;
    step("dirty miss wb2", o_wb());
    pmem_resp = 1'b0;
    step("dirty miss alloc1", o_alloc(1'b0, 1'b0));
    pmem_resp = 1'b1;
    step("dirty miss alloc2 fill", o_alloc(1'b1, 1'b0));
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("dirty miss response", o_hit(1'b1, 1'b0));
    miss_m = sat(miss_m);
    check_counts("after dirty miss");

    // ---------------- request dropped during allocation ----------------
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("drop idle", 11'b0);
    step("drop alloc1", o_alloc(1'b0, 1'b0));
    mem_read = 1'b0;
    step("drop alloc2 held", o_alloc(1'b0, 1'b0));
    pmem_resp = 1'b1;
    step("drop alloc3 resp", o_alloc(1'b1, 1'b0));
    pmem_resp = 1'b0;
    step("drop back to idle", 11'b0);
    check_counts("after dropped miss");
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("hit after dropped miss", o_hit(1'b0, 1'b0));
    hit_m = sat(hit_m);
    check_counts("hit after dropped miss");

    // ---------------- randomized transactions vs. reference model ----------------
    for (int t = 0; t < 200; t++) begin
      int   kind, nw, na;
      logic rd, wr, way, lru, d, tm, vl;
      kind = int'($urandom_range(0, 3));  // 0 idle, 1 hit, 2 clean miss, 3 dirty miss
      case ($urandom_range(0, 2))
        0:       begin rd = 1'b1; wr = 1'b0; end
        1:       begin rd = 1'b0; wr = 1'b1; end
        default: begin rd = 1'b1; wr = 1'b1; end
      endcase
      way = 1'($urandom);
      if (kind == 0) begin
        set_in(1'b0, 1'b0, 1'($urandom), 1'($urandom), way, 1'($urandom), 1'($urandom),
               1'($urandom));
        step("rand idle", 11'b0);
      end else if (kind == 1) begin
        set_in(rd, wr, 1'b1, 1'b1, way, 1'($urandom), 1'($urandom), 1'($urandom));
        step("rand hit", o_hit(wr, way));
        hit_m = sat(hit_m);
      end else begin
        // A miss is either no tag match or a match on an invalid line.
        tm = 1'($urandom);
        vl = tm ? 1'b0 : 1'($urandom);
        d  = (kind == 3);
        set_in(rd, wr, tm, vl, way, d, 1'($urandom), 1'($urandom));
        step("rand miss idle", 11'b0);
        if (d) begin
          nw = int'($urandom_range(1, 4));
          for (int i = 0; i < nw; i++) begin
            set_in(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   1'($urandom), (i == nw - 1));
            step("rand writeback", o_wb());
          end
        end
        na = int'($urandom_range(1, 4));
        lru = 1'b0;
        for (int i = 0; i < na; i++) begin
          lru = 1'($urandom);
          set_in(rd, wr, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 lru, (i == na - 1));
          step("rand allocate", o_alloc(i == na - 1, lru));
        end
        set_in(rd, wr, 1'b1, 1'b1, lru, 1'($urandom), 1'($urandom), 1'($urandom));
        step("rand miss response", o_hit(wr, lru));
        miss_m = sat(miss_m);
      end
      check_counts("rand");
    end

    // ---------------- async reset in the middle of a writeback ----------------
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("reset-mid-wb idle", 11'b0);
    #2;
    check_o("reset-mid-wb before reset", outs, o_wb());
    reset = 1'b1;
    #1;
    check_o("pmem_write falls on async reset", outs, 11'b0);
    hit_m  = 0;
    miss_m = 0;
    check_counts("during async reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step("idle after reset release", 11'b0);
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("hit after reset release", o_hit(1'b0, 1'b1));
    hit_m = sat(hit_m);
    check_counts("after reset release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_control.md
# cache_control

Control state machine for the 2-way set-associative, write-back, write-allocate cache datapath. It sits between the CPU-side memory handshake (mem_read/mem_write/mem_resp) and the physical-memory handshake (pmem_read/pmem_write/pmem_resp). It sequences hit service, dirty-victim writeback and line allocation, and drives every write enable and mux select of the datapath. It also keeps hit/miss statistics counters.

## Interface
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces IDLE and clears counters
- mem_read  in  1  CPU read request, held until mem_resp
- mem_write  in  1  CPU write request, held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to CPU
- pmem_resp  in  1  physical memory completion pulse
- pmem_read  out  1  line fetch request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp; also selects the victim address in the datapath
- tag_match  in  1  some way's tag equals the request tag
- whichtag  in  1  index of the matching way
- valid  in  1  valid bit of the matching way
- dirty  in  1  dirty bit of the LRU (victim) way
- lru_out  in  1  LRU way of the indexed set
- write0  out  1  write tag/data/valid of way 0
- write1  out  1  write tag/data/valid of way 1
- wdirty0  out  1  write dirty bit of way 0
- wdirty1  out  1  write dirty bit of way 1
- dirty0_val  out  1  value written to way 0 dirty bit
- dirty1_val  out  1  value written to way 1 dirty bit
- inrw1  out  1  update the LRU bit to point at the non-accessed way
- inw1  out  1  data-in select: 0 = pmem_rdata line, 1 = merged CPU write line
- hit_count  out  CNT_WIDTH  saturating count of hits
- miss_count  out  CNT_WIDTH  saturating count of misses

## Operation
- States: IDLE, WRITEBACK, ALLOCATE. Outputs are Mealy-decoded from the state and the inputs. Any output not listed for a state or condition is 0.
- hit = tag_match & valid. req = mem_read | mem_write. mem_read and mem_write together are treated as a write.
- IDLE with req & hit:
  - Assert mem_resp and inrw1. Stay in IDLE.
  - On a write, also assert write{whichtag}, wdirty{whichtag} and dirty{whichtag}_val, with inw1=1.
- IDLE with req & !hit:
  - Set the internal flag miss_pending.
  - Go to WRITEBACK if dirty=1, else go to ALLOCATE.
- WRITEBACK:
  - Assert pmem_write.
  - On pmem_resp, go to ALLOCATE.
- ALLOCATE:
  - Assert pmem_read, with inw1=0.
  - On pmem_resp, assert write{lru_out} and wdirty{lru_out}, with dirty{lru_out}_val=0, then go to IDLE.
  - The request is then serviced as a hit in IDLE on the following cycle.
- Counters:
  - On a mem_resp with miss_pending=1, miss_count increments and miss_pending clears.
  - On a mem_resp with miss_pending=0, hit_count increments.
  - Both counters saturate at all-ones.
- If req drops during a miss, the controller still completes the current pmem transaction and returns to IDLE. It clears miss_pending and issues no mem_resp.
- pmem_resp is ignored in IDLE.

## Timing
- Reset values: state IDLE, miss_pending 0, hit_count 0, miss_count 0. Every output is 0 while reset is high.
- Reset asserted mid-WRITEBACK or mid-ALLOCATE abandons the transaction. pmem_read and pmem_write drop immediately.
- Hit latency: mem_resp is asserted in the same cycle the request is presented in IDLE.
- Clean miss: mem_resp arrives 1 cycle after the ALLOCATE pmem_resp cycle. Total latency is 2 + N cycles, where N is the number of ALLOCATE cycles.
- Dirty miss: latency adds the number of WRITEBACK cycles.
- Array, LRU and dirty writes commit on the clock edge ending the cycle in which they are asserted.
- pmem_read and pmem_write are never asserted in the same cycle.

## Test plan
- Reset, then read to an empty set with pmem_resp on the 3rd ALLOCATE cycle:
  - 1 IDLE cycle, then 3 cycles of pmem_read=1, then write{lru_out}=1 with inw1=0, then mem_resp.
  - Final counts: miss_count=1, hit_count=0.
- Read the same address again: mem_resp in the same cycle with inrw1=1, and hit_count=1.
- Write hit on way 1 (whichtag=1):
  - Single cycle with write1=wdirty1=dirty1_val=inw1=inrw1=mem_resp=1.
  - write0=0 and wdirty0=0.
- Miss with dirty=1, lru_out=0:
  - WRITEBACK with pmem_write=1 until pmem_resp.
  - Then ALLOCATE, then write0=1 with wdirty0=1 and dirty0_val=0, then mem_resp.
  - pmem_read and pmem_write never overlap.
- Miss with mem_read dropped after 1 ALLOCATE cycle: pmem_read stays held until pmem_resp, then IDLE, no mem_resp, miss_count unchanged.
- Async reset pulsed mid-WRITEBACK: pmem_write falls with no clock edge, and the state is IDLE with both counters 0 on release.
